// File: rtl/dac_feeder_pkg.sv
// Shared definitions for the DAC sample-buffer feeder: FSM encoding and buffer geometry.
package dac_feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   localparam int HALF_BYTES = 1024;
   localparam int BUF_BYTES  = 2048;

endpackage

// File: rtl/dac_feeder_wr.sv
// Registered byte write port toward the external DAC sample buffer.
// An accepted byte appears on the port exactly one cycle later with we_n low for one cycle.
module dac_feeder_wr
   import dac_feeder_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_data,
   output logic [ADDR_W-1:0] o_addr,
   output logic [7:0]        o_data,
   output logic              o_we_n
);

   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_data;
   logic              r_we_n;

   // Capture the accepted byte and its address; strobe we_n for a single cycle.
   always_ff @(posedge clkin) begin
      if (reset) begin
         r_addr <= {ADDR_W{1'b0}};
         r_data <= 8'd0;
         r_we_n <= 1'b1;
      end else begin
         r_we_n <= ~i_we;
         if (i_we) begin
            r_addr <= i_addr;
            r_data <= i_data;
         end else begin
            r_addr <= r_addr;
            r_data <= r_data;
         end
      end
   end

   assign o_addr = r_addr;
   assign o_data = r_data;
   assign o_we_n = r_we_n;

endmodule

// File: rtl/dac_feeder.sv
// Feeds the DAC sample buffer from the MCU byte stream: primes both halves, starts playback,
// then refills the half the DAC is not playing and flags underruns.
module dac_feeder
   import dac_feeder_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int UCNT_W = 8
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              dac_status,
   output logic [ADDR_W-1:0] pgm_address,
   output logic [7:0]        pgm_data,
   output logic              pgm_we_n,
   output logic              play,
   output logic              dac_reset,
   output logic              underrun,
   output logic [UCNT_W-1:0] underrun_cnt,
   output logic              busy
);

   // Saturating increment for the underrun counter.
   function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
      if (v == {UCNT_W{1'b1}}) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(UCNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] w_next_ptr;
   logic              r_play;
   logic              w_next_play;
   logic              r_dac_reset;
   logic              w_next_dac_reset;
   logic              r_underrun;
   logic              w_next_underrun;
   logic [UCNT_W-1:0] r_underrun_cnt;
   logic [UCNT_W-1:0] w_next_cnt;
   logic              r_dac_status_d;

   logic              w_accept;
   logic              w_half;
   logic              w_half_done;
   logic              w_status_edge;

   assign in_ready      = (r_state == ST_PRIME) || (r_state == ST_RUN);
   assign w_accept      = in_valid && in_ready;
   assign w_half        = r_wr_ptr[ADDR_W-1];
   assign w_half_done   = w_accept && (r_wr_ptr[ADDR_W-2:0] == (ADDR_W-1)'(HALF_BYTES - 1));
   assign w_status_edge = (dac_status != r_dac_status_d);

   // FSM state register.
   always_ff @(posedge clkin) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and next-output decode; stop outranks start, start outranks normal sequencing.
   always_comb begin
      w_next_state     = r_state;
      w_next_ptr       = r_wr_ptr;
      w_next_play      = r_play;
      w_next_dac_reset = 1'b0;
      w_next_underrun  = r_underrun;
      w_next_cnt       = r_underrun_cnt;
      if (w_accept) begin
         w_next_ptr = r_wr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         w_next_ptr = r_wr_ptr;
      end
      if (stop) begin
         w_next_state = ST_IDLE;
         w_next_play  = 1'b0;
      end else if (start) begin
         w_next_state     = ST_PRIME;
         w_next_ptr       = {ADDR_W{1'b0}};
         w_next_play      = 1'b0;
         w_next_dac_reset = 1'b1;
         w_next_underrun  = 1'b0;
         w_next_cnt       = {UCNT_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_next_state = ST_IDLE;
            end
            ST_PRIME: begin
               if (w_accept && (r_wr_ptr == ADDR_W'(BUF_BYTES - 1))) begin
                  w_next_play  = 1'b1;
                  w_next_state = ST_WAIT;
               end else begin
                  w_next_state = ST_PRIME;
               end
            end
            ST_WAIT: begin
               // The half we are about to fill is safe once the DAC has moved off it.
               if (dac_status != w_half) begin
                  w_next_state = ST_RUN;
               end else begin
                  w_next_state = ST_WAIT;
               end
            end
            ST_RUN: begin
               if (w_half_done) begin
                  w_next_state = ST_WAIT;
               end else if (w_status_edge && (dac_status == w_half)) begin
                  // DAC entered the half still being written: count once per entry.
                  w_next_underrun = 1'b1;
                  w_next_cnt      = sat_inc(r_underrun_cnt);
               end else begin
                  w_next_state = ST_RUN;
               end
            end
            default: begin
               w_next_state = ST_IDLE;
            end
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clkin) begin
      if (reset) begin
         r_wr_ptr       <= {ADDR_W{1'b0}};
         r_play         <= 1'b0;
         r_dac_reset    <= 1'b0;
         r_underrun     <= 1'b0;
         r_underrun_cnt <= {UCNT_W{1'b0}};
         r_dac_status_d <= 1'b0;
      end else begin
         r_wr_ptr       <= w_next_ptr;
         r_play         <= w_next_play;
         r_dac_reset    <= w_next_dac_reset;
         r_underrun     <= w_next_underrun;
         r_underrun_cnt <= w_next_cnt;
         r_dac_status_d <= dac_status;
      end
   end

   dac_feeder_wr #(
      .ADDR_W (ADDR_W)
   ) u_wr (
      .clkin  (clkin),
      .reset  (reset),
      .i_we   (w_accept),
      .i_addr (r_wr_ptr),
      .i_data (in_data),
      .o_addr (pgm_address),
      .o_data (pgm_data),
      .o_we_n (pgm_we_n)
   );

   assign play         = r_play;
   assign dac_reset    = r_dac_reset;
   assign underrun     = r_underrun;
   assign underrun_cnt = r_underrun_cnt;
   assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dac_feeder.sv
// Directed, scoreboard-based bench for dac_feeder.
module tb_dac_feeder;

   logic        clkin = 1'b0;
   logic        reset;
   logic        start;
   logic        stop;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        dac_status;
   logic [10:0] pgm_address;
   logic [7:0]  pgm_data;
   logic        pgm_we_n;
   logic        play;
   logic        dac_reset;
   logic        underrun;
   logic [7:0]  underrun_cnt;
   logic        busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [10:0] m_ptr = 11'd0;
   logic [18:0] exp_q[$];
   logic [18:0] e;

   always #5 clkin = ~clkin;

   dac_feeder dut (
      .clkin        (clkin),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .dac_status   (dac_status),
      .pgm_address  (pgm_address),
      .pgm_data     (pgm_data),
      .pgm_we_n     (pgm_we_n),
      .play         (play),
      .dac_reset    (dac_reset),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: at negedge check the write port against the scoreboard and in_ready
   // against the expectation, record a modelled accept, then step past the posedge.
   task automatic tick(input bit exp_rdy);
      @(negedge clkin);
      if (exp_q.size() != 0) begin
         chk("pgm_we_n", pgm_we_n, 0);
         e = exp_q.pop_front();
         chk("pgm_address", pgm_address, e[18:8]);
         chk("pgm_data", pgm_data, e[7:0]);
      end else begin
         chk("pgm_we_n_idle", pgm_we_n, 1);
      end
      chk("in_ready", in_ready, exp_rdy);
      if (in_valid && exp_rdy && !reset) begin
         exp_q.push_back({m_ptr, in_data});
         m_ptr = m_ptr + 11'd1;
      end
      @(posedge clkin);
      #1;
   endtask

   task automatic pulse_start(input bit exp_rdy);
      start = 1'b1;
      tick(exp_rdy);
      start = 1'b0;
      m_ptr = 11'd0;
      chk("dac_reset_pulse", dac_reset, 1);
      chk("busy_after_start", busy, 1);
      chk("play_after_start", play, 0);
      chk("underrun_cleared", underrun, 0);
      chk("ucnt_cleared", underrun_cnt, 0);
   endtask

   task automatic send(input int n, input logic [7:0] xor_key);
      in_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         in_data = m_ptr[7:0] ^ xor_key;
         tick(1'b1);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      in_data = 8'd0; in_valid = 1'b0; dac_status = 1'b0;
      repeat (3) @(posedge clkin);
      #1;
      chk("rst_we_n", pgm_we_n, 1);
      chk("rst_addr", pgm_address, 0);
      chk("rst_data", pgm_data, 0);
      chk("rst_play", play, 0);
      chk("rst_dac_reset", dac_reset, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_ucnt", underrun_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      reset = 1'b0;
      tick(1'b0);

      // Reset held three cycles in the middle of priming.
      pulse_start(1'b0);
      send(10, 8'h3C);
      in_valid = 1'b0;
      reset = 1'b1;
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      reset = 1'b0;
      chk("midrst_we_n", pgm_we_n, 1);
      chk("midrst_play", play, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_addr", pgm_address, 0);
      tick(1'b0);

      // Full prime: 2048 bytes, value = addr[7:0].
      pulse_start(1'b0);
      in_valid = 1'b1;
      in_data = 8'd0;
      tick(1'b1);
      m_ptr = 11'd1;
      chk("dac_reset_single", dac_reset, 0);
      chk("play_during_prime", play, 0);
      send(2047, 8'h00);
      in_valid = 1'b0;
      chk("play_after_prime", play, 1);
      chk("wait_in_ready", in_ready, 0);

      // WAIT holds off until the DAC leaves half 0, then half 0 is refilled.
      repeat (5) tick(1'b0);
      dac_status = 1'b1;
      tick(1'b0);
      chk("run_in_ready", in_ready, 1);
      send(1024, 8'hA5);
      in_valid = 1'b0;
      repeat (5) tick(1'b0);
      chk("no_underrun_refill", underrun, 0);
      dac_status = 1'b0;
      tick(1'b0);
      chk("run_half1_ready", in_ready, 1);

      // Underrun: DAC enters half 1 with only 512 of 1024 bytes written.
      send(512, 8'h5A);
      in_valid = 1'b0;
      dac_status = 1'b1;
      tick(1'b1);
      chk("underrun_set", underrun, 1);
      chk("ucnt_one", underrun_cnt, 1);
      repeat (100) tick(1'b1);
      chk("underrun_sticky", underrun, 1);
      chk("ucnt_held", underrun_cnt, 1);
      pulse_start(1'b1);

      // Half completes in the same cycle the DAC flips onto it: no underrun.
      send(2048, 8'h33);
      in_valid = 1'b0;
      chk("play_reprime", play, 1);
      tick(1'b0);
      send(1023, 8'h0F);
      dac_status = 1'b0;
      in_data = m_ptr[7:0] ^ 8'h0F;
      tick(1'b1);
      in_valid = 1'b0;
      chk("boundary_no_underrun", underrun, 0);
      chk("boundary_wait", in_ready, 0);
      tick(1'b0);
      chk("boundary_run", in_ready, 1);

      // start and stop together while RUN: stop wins; held in_valid is not accepted afterwards.
      send(4, 8'hC3);
      start = 1'b1;
      stop = 1'b1;
      in_data = m_ptr[7:0] ^ 8'hC3;
      tick(1'b1);
      start = 1'b0;
      stop = 1'b0;
      chk("stop_play", play, 0);
      chk("stop_busy", busy, 0);
      chk("stop_no_dac_reset", dac_reset, 0);
      repeat (3) tick(1'b0);
      in_valid = 1'b0;

      // 300 forced underruns saturate the counter at 255.
      pulse_start(1'b0);
      send(2048, 8'h99);
      in_valid = 1'b0;
      tick(1'b0);
      dac_status = 1'b1;
      tick(1'b0);
      for (int k = 1; k <= 300; k++) begin
         dac_status = 1'b0;
         tick(1'b1);
         chk("ucnt_sat", underrun_cnt, (k < 255) ? k : 255);
         dac_status = 1'b1;
         tick(1'b1);
      end
      chk("ucnt_final", underrun_cnt, 255);
      chk("underrun_final", underrun, 1);
      tick(1'b1);
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
